// File: rtl/piso_serializer_pkg.sv
// Shared types for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake, stall control and serial line between a word producer and the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  modport master (
    output pi, load_valid, shift_en,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  pi, load_valid, shift_en,
    output load_ready, so, so_valid, busy, done
  );
endinterface

// File: rtl/sipo4.sv
// 4-bit serial-in/parallel-out receiver; LSB-first bits enter at the top and settle into place.
module sipo4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       si,
  input  logic       en,
  output logic [3:0] po
);

  // Shift register: new bit enters at bit 3 and moves toward bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po <= 4'b0000;
    end else if (en) begin
      po <= {si, po[3:1]};
    end else begin
      po <= po;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Word-to-bit transmitter: valid/ready load, one bit per enabled clock, gapless back-to-back words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             so_bit_s;

  assign last_s   = (cnt_r == {CNT_W{1'b0}});
  // Ready in the last-bit cycle lets the next word follow with no idle gap.
  assign ready_s  = !rst && ((state_r == IDLE) || (last_s && bus.shift_en));
  assign accept_s = bus.load_valid && ready_s;
  assign so_bit_s = LSB_FIRST ? shreg_r[0] : shreg_r[WIDTH-1];

  assign bus.load_ready = ready_s;
  assign bus.so         = (state_r == SHIFT) ? so_bit_s : 1'b0;
  assign bus.so_valid   = (state_r == SHIFT);
  assign bus.busy       = (state_r == SHIFT);
  assign bus.done       = (state_r == SHIFT) && last_s;

  // Control FSM and shift datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SHIFT;
            shreg_r <= bus.pi;
            cnt_r   <= CNT_LAST;
          end else begin
            state_r <= IDLE;
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
          end
        end
        SHIFT: begin
          if (!bus.shift_en) begin
            state_r <= SHIFT;
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
          end else if (!last_s) begin
            state_r <= SHIFT;
            shreg_r <= LSB_FIRST ? {1'b0, shreg_r[WIDTH-1:1]}
                                 : {shreg_r[WIDTH-2:0], 1'b0};
            cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (accept_s) begin
            state_r <= SHIFT;
            shreg_r <= bus.pi;
            cnt_r   <= CNT_LAST;
          end else begin
            state_r <= IDLE;
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          shreg_r <= {WIDTH{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers, with a 4-bit receiver on the LSB-first line.
module tb_piso_serializer;

  typedef struct packed {
    logic so;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] po;
  int         total = 0;
  int         bad   = 0;
  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea;
  exp_t       eb;

  piso_serializer_if #(.WIDTH(4)) ifa ();
  piso_serializer_if #(.WIDTH(4)) ifb ();

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sipo4 rx (.clk(clk), .rst(rst), .si(ifa.so), .en(ifa.so_valid), .po(po));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word_a(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qa.push_back('{so: w[i], done: (i == 3)});
  endtask

  task automatic push_word_b(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qb.push_back('{so: w[3-i], done: (i == 3)});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    tick();
    tick();
  endtask

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    if (ifa.so_valid === 1'b1) begin
      chk("a_busy", ifa.busy, 1);
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_so", ifa.so, ea.so);
        chk("a_done", ifa.done, ea.done);
      end
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (ifb.so_valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_so", ifb.so, eb.so);
        chk("b_done", ifb.done, eb.done);
      end
    end
  end

  initial begin
    ifa.pi = 4'b0000; ifa.load_valid = 1'b0; ifa.shift_en = 1'b0;
    ifb.pi = 4'b0000; ifb.load_valid = 1'b0; ifb.shift_en = 1'b0;
    tick();
    tick();
    chk("rst_ready_a", ifa.load_ready, 0);
    chk("rst_valid_a", ifa.so_valid, 0);
    chk("rst_ready_b", ifb.load_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_a", ifa.load_ready, 1);
    chk("post_rst_ready_b", ifb.load_ready, 1);

    // Single word 1011, loopback into the receiver.
    ifa.pi = 4'b1011; ifa.load_valid = 1'b1; ifa.shift_en = 1'b1;
    push_word_a(4'b1011);
    tick();
    ifa.load_valid = 1'b0;
    chk("single_ready_busy", ifa.load_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("loopback_po", po, 4'b1011);
    chk("single_idle_valid", ifa.so_valid, 0);
    drain();

    // Back-to-back 1011 then 0100 with load_valid held high.
    ifa.pi = 4'b1011; ifa.load_valid = 1'b1;
    push_word_a(4'b1011);
    push_word_a(4'b0100);
    tick();
    ifa.pi = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready_w0", ifa.load_ready, (i == 3));
      tick();
    end
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready_w1", ifa.load_ready, (i == 3));
      tick();
    end
    chk("b2b_end_ready", ifa.load_ready, 1);
    drain();

    // Stall three cycles after the second bit.
    ifa.pi = 4'b1011; ifa.load_valid = 1'b1; ifa.shift_en = 1'b1;
    qa.push_back('{so: 1'b1, done: 1'b0});
    for (int i = 0; i < 4; i++) qa.push_back('{so: 1'b1, done: 1'b0});
    qa.push_back('{so: 1'b0, done: 1'b0});
    qa.push_back('{so: 1'b1, done: 1'b1});
    tick();
    ifa.load_valid = 1'b0;
    tick();
    ifa.shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", ifa.load_ready, 0);
      tick();
    end
    ifa.shift_en = 1'b1;
    drain();

    // Reset pulse after the second bit, then a clean word 0110.
    ifa.pi = 4'b1011; ifa.load_valid = 1'b1;
    qa.push_back('{so: 1'b1, done: 1'b0});
    qa.push_back('{so: 1'b1, done: 1'b0});
    tick();
    ifa.load_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_so", ifa.so, 0);
    chk("mid_rst_valid", ifa.so_valid, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_done", ifa.done, 0);
    chk("mid_rst_ready", ifa.load_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("after_rst_ready", ifa.load_ready, 1);
    tick();
    ifa.pi = 4'b0110; ifa.load_valid = 1'b1;
    push_word_a(4'b0110);
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("loopback_po_0110", po, 4'b0110);
    drain();

    // MSB-first instance; shift_en low in IDLE must not block the load.
    ifb.pi = 4'b1011; ifb.load_valid = 1'b1; ifb.shift_en = 1'b0;
    chk("b_idle_ready_no_en", ifb.load_ready, 1);
    push_word_b(4'b1011);
    tick();
    ifb.load_valid = 1'b0;
    ifb.shift_en = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
